// File: rtl/mastermind_pkg.sv
// Shared definitions for the mastermind round tracker: game state encodings,
// peg geometry and the packed width of one history entry.
package mastermind_pkg;

  localparam int PEGS   = 4;
  localparam int SYM_W  = 3;
  localparam int CNT_W  = 3;
  localparam int HIST_W = PEGS * SYM_W + 2 * CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAYING = 2'b01,
    ST_WON     = 2'b10,
    ST_LOST    = 2'b11
  } game_state_t;

  // A score is impossible if more pegs are matched than exist.
  function automatic logic score_illegal(input logic [CNT_W-1:0] red,
                                         input logic [CNT_W-1:0] white,
                                         input int pegs);
    logic [CNT_W:0] sum;
    sum = {1'b0, red} + {1'b0, white};
    return (sum > (CNT_W+1)'(pegs)) || ({1'b0, red} > (CNT_W+1)'(pegs));
  endfunction

endpackage

// File: rtl/mastermind_round_tracker_if.sv
// Controller <-> round tracker bundle. master = controller / display side,
// slave = tracker.
interface mastermind_round_tracker_if #(
  parameter int PEGS  = 4,
  parameter int SYM_W = 3
);
  logic                    code_loaded;
  logic                    new_game;
  logic                    result_valid;
  logic [PEGS*SYM_W-1:0]   guess_in;
  logic [2:0]              red_in;
  logic [2:0]              white_in;
  logic                    view_step;
  logic                    guess_en;
  logic [3:0]              round_cnt;
  logic [1:0]              game_state;
  logic [2:0]              view_idx;
  logic [PEGS*SYM_W-1:0]   view_guess;
  logic [2:0]              view_red;
  logic [2:0]              view_white;
  logic                    score_err;

  modport master (
    output code_loaded, new_game, result_valid, guess_in, red_in, white_in,
           view_step,
    input  guess_en, round_cnt, game_state, view_idx, view_guess, view_red,
           view_white, score_err
  );

  modport slave (
    input  code_loaded, new_game, result_valid, guess_in, red_in, white_in,
           view_step,
    output guess_en, round_cnt, game_state, view_idx, view_guess, view_red,
           view_white, score_err
  );
endinterface

// File: rtl/mastermind_hist_ram.sv
// Round history storage: one write port, one registered read port with
// write-first forwarding and a synchronous clear of the read register.
module mastermind_hist_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 18,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  input  logic          clr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; clr forces the readout to zero when nothing is logged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     rdata <= '0;
    else if (clr)                    rdata <= '0;
    else if (we && (waddr == raddr)) rdata <= wdata;
    else                             rdata <= mem[raddr];
  end

endmodule

// File: rtl/mastermind_round_tracker.sv
// Logs each scored guess, counts rounds, declares win/loss and drives a
// scrollable registered history readout.
module mastermind_round_tracker #(
  parameter int MAX_ROUNDS = 8,
  parameter int PEGS       = mastermind_pkg::PEGS,
  parameter int SYM_W      = mastermind_pkg::SYM_W
) (
  input  logic                        clk,
  input  logic                        resetn,
  mastermind_round_tracker_if.slave   bus
);
  import mastermind_pkg::*;

  localparam int GW = PEGS * SYM_W;
  localparam int EW = GW + 2 * CNT_W;

  game_state_t   state;
  logic [3:0]    round_cnt;
  logic [2:0]    view_idx;
  logic          score_err;
  logic          start;
  logic          accept;
  logic          illegal;
  logic          win;
  logic          rd_clr;
  logic [3:0]    view_nxt;
  logic [EW-1:0] rd_data;

  // new_game beats everything else in the same cycle.
  assign start   = (state == ST_IDLE) && bus.code_loaded && !bus.new_game;
  assign accept  = (state == ST_PLAYING) && bus.result_valid && !bus.new_game &&
                   (round_cnt < 4'(MAX_ROUNDS));
  assign illegal = score_illegal(bus.red_in, bus.white_in, PEGS);
  assign win     = (bus.red_in == 3'(PEGS)) && !illegal;
  assign view_nxt = {1'b0, view_idx} + 4'd1;

  // Readout goes to zero with an empty history, including the cycle a game starts.
  assign rd_clr  = (round_cnt == 4'd0) || start;

  // Game FSM, round counter and sticky score error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
      score_err <= 1'b0;
    end else if (bus.new_game) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.code_loaded) begin
            state     <= ST_PLAYING;
            round_cnt <= '0;
            score_err <= 1'b0;
          end
        end
        ST_PLAYING: begin
          if (accept) begin
            round_cnt <= round_cnt + 4'd1;
            if (illegal) score_err <= 1'b1;
            if (win)                                     state <= ST_WON;
            else if (round_cnt + 4'd1 == 4'(MAX_ROUNDS)) state <= ST_LOST;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // View pointer: clear on start, follow writes, otherwise scroll with wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 view_idx <= '0;
    else if (start)                              view_idx <= '0;
    else if (accept)                             view_idx <= round_cnt[2:0];
    else if (bus.view_step && round_cnt != 4'd0) view_idx <= (view_nxt == round_cnt) ? 3'd0 : view_nxt[2:0];
  end

  mastermind_hist_ram #(
    .DEPTH (MAX_ROUNDS),
    .W     (EW),
    .AW    (3)
  ) u_hist (
    .clk    (clk),
    .resetn (resetn),
    .we     (accept),
    .waddr  (round_cnt[2:0]),
    .wdata  ({bus.guess_in, bus.red_in, bus.white_in}),
    .raddr  (view_idx),
    .clr    (rd_clr),
    .rdata  (rd_data)
  );

  assign bus.guess_en   = (state == ST_PLAYING);
  assign bus.game_state = state;
  assign bus.round_cnt  = round_cnt;
  assign bus.view_idx   = view_idx;
  assign bus.score_err  = score_err;
  assign {bus.view_guess, bus.view_red, bus.view_white} = rd_data;

endmodule

// File: tb/tb_mastermind_round_tracker.sv
// Bench for mastermind_round_tracker: directed scenarios plus a randomized
// game sequence checked against a rule-level reference model.
module tb_mastermind_round_tracker;

  localparam int MAXR = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mastermind_round_tracker_if #(.PEGS(4), .SYM_W(3)) bus ();

  mastermind_round_tracker #(.MAX_ROUNDS(MAXR), .PEGS(4), .SYM_W(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int npass = 0;
  int ntotal = 0;

  // Reference model: game state 0 idle 1 playing 2 won 3 lost.
  int          m_state, m_cnt, m_view;
  bit          m_err;
  logic [11:0] m_g [MAXR];
  int          m_r [MAXR];
  int          m_w [MAXR];

  function automatic logic [10:0] exp_status();
    return {2'(m_state), 4'(m_cnt), 3'(m_view), m_err, (m_state == 1)};
  endfunction

  function automatic logic [17:0] exp_view();
    if (m_cnt == 0) return '0;
    return {m_g[m_view], 3'(m_r[m_view]), 3'(m_w[m_view])};
  endfunction

  function automatic logic [10:0] got_status();
    return {bus.game_state, bus.round_cnt, bus.view_idx, bus.score_err, bus.guess_en};
  endfunction

  function automatic logic [17:0] got_view();
    return {bus.view_guess, bus.view_red, bus.view_white};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_view = 0; m_err = 0;
  endtask

  // One clock cycle with the given pulses, then the model applies the rules.
  task automatic cyc(input bit cl, input bit ng, input bit rv, input bit vs,
                     input logic [11:0] g = '0, input int r = 0, input int w = 0);
    bit bad;
    bus.code_loaded = cl; bus.new_game = ng; bus.result_valid = rv; bus.view_step = vs;
    bus.guess_in = g; bus.red_in = 3'(r); bus.white_in = 3'(w);
    @(posedge clk); #1;
    bus.code_loaded = 0; bus.new_game = 0; bus.result_valid = 0; bus.view_step = 0;
    if (ng) m_state = 0;
    else if (m_state == 0 && cl) begin
      m_state = 1; m_cnt = 0; m_view = 0; m_err = 0;
    end else if (m_state == 1 && rv) begin
      bad = (r > 4) || (r + w > 4);
      m_g[m_cnt] = g; m_r[m_cnt] = r; m_w[m_cnt] = w;
      m_view = m_cnt;
      m_cnt++;
      if (bad) m_err = 1;
      if (r == 4 && !bad) m_state = 2;
      else if (m_cnt == MAXR) m_state = 3;
    end else if (vs && m_cnt != 0) m_view = (m_view + 1) % m_cnt;
  endtask

  task automatic idle(); cyc(0, 0, 0, 0); endtask

  task automatic test_reset();
    resetn = 0;
    repeat (3) @(posedge clk); #1;
    model_reset();
    ntotal++; if (got_status() !== 11'd0) $display("FAIL reset_status got %h exp %h", got_status(), 11'd0); else npass++;
    ntotal++; if (got_view() !== 18'd0) $display("FAIL reset_view got %h exp %h", got_view(), 18'd0); else npass++;
    resetn = 1;
    idle();
  endtask

  task automatic test_win();
    cyc(1, 0, 0, 0);
    ntotal++; if (got_status() !== 11'b01_0000_000_0_1) $display("FAIL win_start got %h exp %h", got_status(), 11'b01_0000_000_0_1); else npass++;
    ntotal++; if (got_view() !== 18'd0) $display("FAIL win_start_view got %h exp 0", got_view()); else npass++;
    cyc(0, 0, 1, 0, 12'o7001, 1, 2);
    cyc(0, 0, 1, 0, 12'o7002, 2, 1);
    cyc(0, 0, 1, 0, 12'o1234, 4, 0);
    ntotal++; if (got_status() !== 11'b10_0011_010_0_0) $display("FAIL win_status got %h exp %h", got_status(), 11'b10_0011_010_0_0); else npass++;
    idle();
    ntotal++; if (got_view() !== {12'o1234, 3'd4, 3'd0}) $display("FAIL win_view got %h exp %h", got_view(), {12'o1234, 3'd4, 3'd0}); else npass++;
    cyc(0, 0, 1, 0, 12'o5555, 1, 1);
    idle();
    ntotal++; if (got_status() !== exp_status() || bus.round_cnt !== 4'd3) $display("FAIL win_hold got %h exp %h", got_status(), exp_status()); else npass++;
  endtask

  task automatic test_lose();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < MAXR; i++) begin
      cyc(0, 0, 1, 0, 12'($urandom), 1, 0);
      ntotal++; if (got_status() !== exp_status()) $display("FAIL lose_round%0d got %h exp %h", i, got_status(), exp_status()); else npass++;
    end
    ntotal++; if (bus.game_state !== 2'b11 || bus.round_cnt !== 4'd8) $display("FAIL lose_final got %b/%0d exp 11/8", bus.game_state, bus.round_cnt); else npass++;
    cyc(0, 0, 1, 0, 12'o7777, 3, 0);
    idle();
    ntotal++; if (got_view() !== exp_view() || got_status() !== exp_status()) $display("FAIL lose_ninth got %h/%h exp %h/%h", got_status(), got_view(), exp_status(), exp_view()); else npass++;
  endtask

  task automatic test_view_wrap();
    int r;
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, 3);
      cyc(0, 0, 1, 0, 12'($urandom), r, $urandom_range(0, 4 - r));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      ntotal++; if (int'(bus.view_idx) !== ((i == 3) ? 0 : i)) $display("FAIL view_idx%0d got %0d exp %0d", i, bus.view_idx, (i == 3) ? 0 : i); else npass++;
      idle();
      ntotal++; if (got_view() !== exp_view()) $display("FAIL view_data%0d got %h exp %h", i, got_view(), exp_view()); else npass++;
    end
  endtask

  task automatic test_illegal();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0, 12'o3210, 3, 3);
    ntotal++; if (got_status() !== 11'b01_0001_000_1_1) $display("FAIL illegal_sum got %h exp %h", got_status(), 11'b01_0001_000_1_1); else npass++;
    cyc(0, 0, 1, 0, 12'o4567, 5, 0);
    ntotal++; if (got_status() !== 11'b01_0010_001_1_1) $display("FAIL illegal_red got %h exp %h", got_status(), 11'b01_0010_001_1_1); else npass++;
    idle();
    ntotal++; if (got_view() !== {12'o4567, 3'd5, 3'd0}) $display("FAIL illegal_view got %h exp %h", got_view(), {12'o4567, 3'd5, 3'd0}); else npass++;
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    ntotal++; if (bus.score_err !== 1'b0 || got_status() !== exp_status()) $display("FAIL illegal_clear got %h exp %h", got_status(), exp_status()); else npass++;
  endtask

  task automatic test_new_game_priority();
    cyc(0, 0, 1, 0, 12'o1111, 0, 1);
    cyc(0, 0, 1, 0, 12'o2222, 2, 0);
    cyc(0, 1, 1, 0, 12'o3333, 4, 0);
    ntotal++; if (got_status() !== 11'b00_0010_001_0_0) $display("FAIL ng_prio got %h exp %h", got_status(), 11'b00_0010_001_0_0); else npass++;
    idle();
    ntotal++; if (got_view() !== {12'o2222, 3'd2, 3'd0}) $display("FAIL ng_view got %h exp %h", got_view(), {12'o2222, 3'd2, 3'd0}); else npass++;
  endtask

  task automatic test_random();
    int op, r, w;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 99);
      if (op < 50) begin
        if ($urandom_range(0, 9) == 0) begin
          r = $urandom_range(0, 3); w = $urandom_range(5 - r, 7);
        end else begin
          r = $urandom_range(0, 4); w = $urandom_range(0, 4 - r);
        end
        cyc(0, 0, 1, $urandom_range(0, 1), 12'($urandom), r, w);
      end else if (op < 80) cyc(0, 0, 0, 1);
      else if (op < 88) cyc(0, 1, 0, 0);
      else cyc(1, 0, 0, 0);
      idle();
      ntotal++; if (got_status() !== exp_status()) $display("FAIL rand_status%0d got %h exp %h", i, got_status(), exp_status()); else npass++;
      ntotal++; if (got_view() !== exp_view()) $display("FAIL rand_view%0d got %h exp %h", i, got_view(), exp_view()); else npass++;
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0, 12'o6543, 2, 2);
    idle();
    @(posedge clk); #3;
    resetn = 0;
    #1;
    ntotal++; if (got_status() !== 11'd0) $display("FAIL async_status got %h exp 0", got_status()); else npass++;
    ntotal++; if (got_view() !== 18'd0) $display("FAIL async_view got %h exp 0", got_view()); else npass++;
    model_reset();
    @(negedge clk);
    resetn = 1;
    idle();
  endtask

  initial begin
    bus.code_loaded = 0; bus.new_game = 0; bus.result_valid = 0; bus.view_step = 0;
    bus.guess_in = '0; bus.red_in = '0; bus.white_in = '0;
    model_reset();
    test_reset();
    test_win();
    test_lose();
    test_view_wrap();
    test_illegal();
    test_new_game_priority();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/mastermind_round_tracker.md
Name: mastermind_round_tracker

Overview:
- Downstream of the mastermind datapath/compare stage.
- Consumes each completed scoring pass (guess, red count, white count, completion strobe), logs it into a round-history buffer, and counts rounds.
- Declares WIN on red==4 and LOSS when MAX_ROUNDS is exhausted.
- Provides a scrollable, registered history readout for HEX display plus a guess-enable back to the controller.

Parameters:
- MAX_ROUNDS, 8, number of guesses allowed per game (2..8).
- PEGS, 4, code length; win when red==PEGS.
- SYM_W, 3, bits per peg symbol.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- code_loaded  in  1  one-cycle pulse: secret code fully entered, start game
- new_game  in  1  one-cycle pulse: abandon/finish game, return to IDLE
- result_valid  in  1  one-cycle pulse: red_in/white_in/guess_in are final for this round
- guess_in  in  PEGS*SYM_W  guess just scored
- red_in  in  3  exact-position matches
- white_in  in  3  colour-only matches
- view_step  in  1  one-cycle pulse: advance history view pointer
- guess_en  out  1  high only in PLAYING; controller may accept guess digits
- round_cnt  out  4  rounds completed this game
- game_state  out  2  00 IDLE, 01 PLAYING, 10 WON, 11 LOST
- view_idx  out  3  history entry currently displayed
- view_guess  out  PEGS*SYM_W  guess at view_idx (registered)
- view_red  out  3  red at view_idx (registered)
- view_white  out  3  white at view_idx (registered)
- score_err  out  1  sticky: an illegal score was received

Behaviour:
- Reset (async, resetn=0): state IDLE; round_cnt=0, view_idx=0, view_* = 0, score_err=0, guess_en=0. History contents are not reset; entries are only readable once written.
- FSM, one transition per clk:
  - IDLE: code_loaded -> PLAYING; round_cnt<=0, view_idx<=0, score_err<=0.
  - PLAYING: on result_valid, write entry[round_cnt] = {guess_in, red_in, white_in} and set round_cnt<=round_cnt+1. Then:
    - red_in==PEGS -> WON.
    - otherwise, round_cnt+1==MAX_ROUNDS -> LOST.
    - otherwise stay in PLAYING.
  - WON/LOST: hold. result_valid and code_loaded are ignored. Only new_game (or reset) leaves.
  - new_game in any state -> IDLE. It has priority over result_valid and code_loaded in the same cycle; no history write occurs.
- Illegal score: red_in+white_in>PEGS, or red_in>PEGS, with result_valid in PLAYING.
  - Entry is still written and round still counts.
  - score_err set (sticky until the next code_loaded or reset).
  - Illegal red never triggers WON.
- result_valid outside PLAYING: no write, no count change.
- round_cnt saturates at MAX_ROUNDS; never wraps.
- View pointer:
  - view_step when round_cnt==0: view_idx stays 0.
  - Otherwise view_idx <= (view_idx+1==round_cnt) ? 0 : view_idx+1.
- Auto-follow: on each accepted history write, view_idx <= index just written. Write takes priority over a simultaneous view_step.
- Readout latency: view_guess/view_red/view_white reflect view_idx one cycle after view_idx changes. The readout port also shows the just-written entry one cycle after the write (write-first forwarding).
- When round_cnt==0, view_* outputs read 0.
- guess_en = (state==PLAYING), combinational from the state register.

Decomposition:
- Shared package mastermind_pkg holds:
  - game_state encodings (IDLE/PLAYING/WON/LOST);
  - PEGS and SYM_W constants;
  - a hist_entry width constant (PEGS*SYM_W+6).
- Sub-module mastermind_hist_ram: MAX_ROUNDS x hist_entry, 1 write / 1 registered read, write-first. Tracker owns the FSM, counters, pointer and error logic.

Test Plan:
- Reset then code_loaded -> game_state=01, guess_en=1, round_cnt=0, view_* = 0.
- Three result_valid with (red,white) = (1,2), (2,1), (4,0), guess 12'o1234 on the last -> round_cnt=3, game_state=10, view_idx=2, view_red=4 one cycle later. A further result_valid is ignored (round_cnt stays 3).
- 8 result_valid, all red=1 white=0 -> game_state=11 right after the 8th, round_cnt=8. A 9th pulse produces no write.
- After 3 rounds, pulse view_step 4 times -> view_idx sequence 0,1,2,0. Each view_red/view_white matches the stored round one cycle after the step.
- result_valid with red=3 white=3 -> score_err=1, state stays PLAYING, round counted. Then red=5 white=0 -> no WON, score_err still 1. Next code_loaded clears score_err.
- new_game and result_valid in the same cycle while PLAYING -> IDLE, round_cnt unchanged, no write.
- resetn asserted low mid-game, asynchronous to clk -> all outputs return to reset values immediately.
